// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg -- shared definitions for the pipe_stage_256 block.
//   DATA_W    : width of one pipe word
//   LANE_W    : width of one independent arithmetic lane
//   NUM_LANES : lanes per pipe word
//   state_e   : burst controller states
package pipe_stage_pkg;

    localparam int DATA_W    = 256;
    localparam int LANE_W    = 32;
    localparam int NUM_LANES = DATA_W / LANE_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/pipe_stage_256_lane_adder.sv
// lane_adder -- purely combinational lane-wise adder.
// Every LANE_W slice of data_i gets inc_i added modulo 2^LANE_W; carries
// never cross a lane boundary.
// Ports:
//   data_i [DATA_W]  word to transform
//   inc_i  [LANE_W]  constant added to every lane
//   sum_o  [DATA_W]  transformed word
module lane_adder #(
    parameter int DATA_W = pipe_stage_pkg::DATA_W,
    parameter int LANE_W = pipe_stage_pkg::LANE_W
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic [LANE_W-1:0] inc_i,
    output logic [DATA_W-1:0] sum_o
);

    localparam int LANES = DATA_W / LANE_W;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // LANE_W-bit result truncates the carry out of each lane
            assign sum_o[gi*LANE_W +: LANE_W] = data_i[gi*LANE_W +: LANE_W] + inc_i;
        end
    endgenerate

endmodule

// File: rtl/pipe_stage_256.sv
// pipe_stage_256 -- burst mover between an input FIFO and an output FIFO.
// Waits until a full burst is available upstream and room for a full burst
// exists downstream, then reads BURST_LEN words, adds lane_inc to every lane
// and writes the results two cycles after each read.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   enable                         permit new bursts (running bursts finish)
//   lane_inc [LANE_W]              per-lane additive constant
//   pipe_in_data/valid/empty       input FIFO dout, dout valid, empty
//   pipe_in_rd_count [CNT_W]       input FIFO fill level
//   pipe_in_read                   input FIFO rd_en
//   pipe_out_data/write            output FIFO din, wr_en
//   pipe_out_full                  output FIFO full
//   pipe_out_wr_count [CNT_W]      output FIFO fill level
//   busy                           controller not idle
//   word_count [32]                words written since reset (wraps)
//   overflow_err                   sticky: a write happened while full
//   checksum [LANE_W]              only with PIPE_STAGE_CHECKSUM_EN defined:
//                                  running XOR of all lanes of written words
module pipe_stage_256 #(
    parameter int DATA_W    = pipe_stage_pkg::DATA_W,
    parameter int LANE_W    = pipe_stage_pkg::LANE_W,
    parameter int BURST_LEN = 16,
    parameter int OUT_DEPTH = 128,
    parameter int CNT_W     = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [LANE_W-1:0] lane_inc,
    input  logic [DATA_W-1:0] pipe_in_data,
    input  logic              pipe_in_valid,
    input  logic              pipe_in_empty,
    input  logic [CNT_W-1:0]  pipe_in_rd_count,
    output logic              pipe_in_read,
    output logic [DATA_W-1:0] pipe_out_data,
    output logic              pipe_out_write,
    input  logic              pipe_out_full,
    input  logic [CNT_W-1:0]  pipe_out_wr_count,
    output logic              busy,
    output logic [31:0]       word_count,
    output logic              overflow_err
`ifdef PIPE_STAGE_CHECKSUM_EN
    ,
    output logic [LANE_W-1:0] checksum
`endif
);

    import pipe_stage_pkg::*;

    localparam int LANES = DATA_W / LANE_W;
    localparam int BC_W  = $clog2(BURST_LEN + 1);

    localparam logic [BC_W-1:0]  LAST_READ = BC_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] RD_THRESH = CNT_W'(BURST_LEN);
    // Four words of headroom beyond the burst cover words already in
    // flight when the downstream count was sampled.
    localparam logic [CNT_W-1:0] WR_LIMIT  = CNT_W'(OUT_DEPTH - BURST_LEN - 4);

    // ------------------------------------------------------------------
    // Burst controller
    // ------------------------------------------------------------------
    state_e          state_q;
    logic [BC_W-1:0] burst_cnt_q;
    logic            drain_cnt_q;
    logic            start_ok;
    logic            rd_en;

    assign start_ok = enable && (pipe_in_rd_count >= RD_THRESH)
                             && (pipe_out_wr_count <= WR_LIMIT);

    // rd_en must follow empty in the same cycle: a registered version would
    // act on last cycle's empty and could underflow the FIFO.
    assign rd_en = (state_q == BURST) && !pipe_in_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
            drain_cnt_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q     <= BURST;
                        burst_cnt_q <= '0;
                    end
                end
                BURST: begin
                    if (rd_en) begin
                        if (burst_cnt_q == LAST_READ) begin
                            state_q     <= DRAIN;
                            burst_cnt_q <= '0;
                            drain_cnt_q <= 1'b0;
                        end else begin
                            burst_cnt_q <= burst_cnt_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    // two quiet cycles let the last read's word land
                    if (drain_cnt_q) begin
                        state_q     <= IDLE;
                        drain_cnt_q <= 1'b0;
                    end else begin
                        drain_cnt_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pipe_in_read = rd_en;
    assign busy         = (state_q != IDLE);

    // ------------------------------------------------------------------
    // Data path: transform and register every valid word
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] sum_word;

    lane_adder #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_lane_adder (
        .data_i (pipe_in_data),
        .inc_i  (lane_inc),
        .sum_o  (sum_word)
    );

    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_write_q, out_write_d;
    logic [31:0]       word_count_q, word_count_d;
    logic              overflow_q, overflow_d;

    always_comb begin
        out_data_d   = out_data_q;
        out_write_d  = pipe_in_valid;
        word_count_d = word_count_q;
        overflow_d   = overflow_q;
        if (pipe_in_valid) begin
            out_data_d = sum_word;
        end
        if (out_write_q) begin
            word_count_d = word_count_q + 32'd1;
            // the write is still issued; only the error is recorded
            overflow_d   = overflow_q | pipe_out_full;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_write_q  <= 1'b0;
            word_count_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            out_data_q   <= out_data_d;
            out_write_q  <= out_write_d;
            word_count_q <= word_count_d;
            overflow_q   <= overflow_d;
        end
    end

    assign pipe_out_data  = out_data_q;
    assign pipe_out_write = out_write_q;
    assign word_count     = word_count_q;
    assign overflow_err   = overflow_q;

`ifdef PIPE_STAGE_CHECKSUM_EN
    // ------------------------------------------------------------------
    // Optional checksum, folded in on the edge that launches the write so
    // it already includes the word shown on pipe_out_data.
    // ------------------------------------------------------------------
    logic [LANE_W-1:0] lane_xor;
    logic [LANE_W-1:0] checksum_q, checksum_d;

    always_comb begin
        lane_xor = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_xor = lane_xor ^ sum_word[i*LANE_W +: LANE_W];
        end
    end

    always_comb begin
        checksum_d = checksum_q;
        if (pipe_in_valid) begin
            checksum_d = checksum_q ^ lane_xor;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_q <= '0;
        end else begin
            checksum_q <= checksum_d;
        end
    end

    assign checksum = checksum_q;
`endif

endmodule

// File: doc/pipe_stage_256.md
PIPE_STAGE_256 -- requirements
Module: pipe_stage_256

Interface
REQ-001 SHALL have parameters: DATA_W, 256, pipe word width; LANE_W, 32, lane width; BURST_LEN, 16, words per burst; OUT_DEPTH, 128, output FIFO depth; CNT_W, 7, FIFO count width.
REQ-002 SHALL have one clock and an asynchronous, active-low reset: clk  in  1  sole clock; rst_n  in  1  asynchronous active-low reset.
REQ-003 SHALL have ports: enable  in  1  permit new bursts.
REQ-004 lane_inc  in  LANE_W  per-lane additive constant.
REQ-005 pipe_in_data  in  DATA_W  input FIFO dout.
REQ-006 pipe_in_valid  in  1  input FIFO dout valid, one cycle after read.
REQ-007 pipe_in_empty  in  1  input FIFO empty.
REQ-008 pipe_in_rd_count  in  CNT_W  input FIFO read count.
REQ-009 pipe_in_read  out  1  input FIFO rd_en.
REQ-010 pipe_out_data  out  DATA_W  output FIFO din.
REQ-011 pipe_out_write  out  1  output FIFO wr_en.
REQ-012 pipe_out_full  in  1  output FIFO full.
REQ-013 pipe_out_wr_count  in  CNT_W  output FIFO write count.
REQ-014 busy  out  1  state != IDLE.
REQ-015 word_count  out  32  words written since reset, wraps mod 2^32.
REQ-016 overflow_err  out  1  sticky: write attempted while pipe_out_full.

Function
REQ-017 States: IDLE, BURST, DRAIN.
REQ-018 IDLE->BURST when enable=1, pipe_in_rd_count>=BURST_LEN and pipe_out_wr_count<=OUT_DEPTH-BURST_LEN-4 (space reserved for whole burst).
REQ-019 BURST: pipe_in_read=1 iff pipe_in_empty=0; burst counter increments per issued read; after BURST_LEN-th read -> DRAIN.
REQ-020 DRAIN: pipe_in_read=0 for 2 cycles (in-flight words land), then -> IDLE.
REQ-021 Deassertion of enable mid-burst does not abort; burst completes, then IDLE.
REQ-022 Transform: lane i of pipe_out_data = lane i of pipe_in_data + lane_inc, modulo 2^LANE_W, no carry between lanes.
REQ-023 pipe_out_write=1 and pipe_out_data registered exactly one cycle after pipe_in_valid=1; read-to-write latency 2 cycles.
REQ-024 Every word with pipe_in_valid=1 is written; none dropped or duplicated.
REQ-025 word_count increments on each pipe_out_write; 0xFFFFFFFF wraps to 0.
REQ-026 overflow_err sets when pipe_out_write=1 and pipe_out_full=1; write still issued; cleared only by reset.
REQ-027 pipe_in_empty=1 mid-burst stalls reads; state holds BURST until remaining reads issue.

Reset
REQ-028 rst_n=0 asynchronously forces IDLE, burst counter 0, pipe_in_read=0, pipe_out_write=0, pipe_out_data=0, word_count=0, overflow_err=0, busy=0.
REQ-029 Reset mid-burst discards in-flight words; first burst after release restarts from REQ-018.

Configuration
REQ-030 PIPE_STAGE_CHECKSUM_EN defined: adds output checksum [LANE_W], XOR of all lanes of every written word, reset 0, updated same cycle as pipe_out_write.
REQ-031 PIPE_STAGE_CHECKSUM_EN undefined: no checksum port, no checksum logic; all other behaviour identical.

Structure
REQ-032 Package pipe_stage_pkg holds DATA_W, LANE_W, NUM_LANES=DATA_W/LANE_W and state enum.
REQ-033 One sub-module, lane_adder: combinational NUM_LANES-way lane-wise adder; registers stay in pipe_stage_256.

Verification
REQ-034 rd_count=16, wr_count=0, enable=1, lane_inc=1, lanes 0x00000000 -> 16 reads, 16 writes, lanes 0x00000001, word_count=16.
REQ-035 Lane 0xFFFFFFFF, lane_inc=1 -> that lane 0x00000000, neighbouring lanes unaffected.
REQ-036 wr_count=121 at IDLE -> no burst; drop to 108 -> burst starts next cycle.
REQ-037 enable falls after 3rd read -> all 16 reads/writes complete, then IDLE, no new burst.
REQ-038 rst_n low after 5th read -> outputs 0 immediately; no write for in-flight words; word_count=0.
REQ-039 With PIPE_STAGE_CHECKSUM_EN, one word of lanes 1..8, lane_inc=0 -> checksum=0x00000008; pipe_out_full forced during write -> overflow_err=1 sticky.
